// File: rtl/dswitch_serializer.sv
// dswitch_serializer
//   Takes a parallel word through a valid/ready handshake and sends it out
//   one bit per rising clk edge. It is the transmit-side partner of a DSwitch
//   capture register. All outputs are registered.
//
//   Optional feature: define DSWITCH_SER_PARITY_EN to append one even-parity
//   bit (the XOR of the accepted word) after the data bits.
//
// Parameters
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   load_valid  producer has a word on din
//   load_ready  block can accept a word this cycle
//   din         parallel word, sampled only at the handshake
//   sout        serial data bit
//   sout_valid  sout carries a frame bit this cycle
//   done        single-cycle pulse after the last frame bit
module dswitch_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
`ifdef DSWITCH_SER_PARITY_EN
        ,
        S_PAR   = 2'd3
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_ready_q, load_ready_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shifted;
`ifdef DSWITCH_SER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef DSWITCH_SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            load_ready_q <= load_ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
`ifdef DSWITCH_SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next state and next registered outputs. The bit currently on sout sits
    // at the outgoing end of shift_q; the value computed here is what the
    // registers will show in the following cycle.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        load_ready_d = 1'b0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;
`ifdef DSWITCH_SER_PARITY_EN
        parity_d     = parity_q;
`endif
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_q[WIDTH-1:1]};
        end

        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    state_d      = S_SHIFT;
                    shift_d      = din;
                    cnt_d        = '0;
                    sout_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
                    sout_valid_d = 1'b1;
`ifdef DSWITCH_SER_PARITY_EN
                    parity_d     = ^din;
`endif
                end else begin
                    load_ready_d = 1'b1;
                end
            end

            S_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef DSWITCH_SER_PARITY_EN
                    state_d      = S_PAR;
                    sout_d       = parity_q;
                    sout_valid_d = 1'b1;
`else
                    state_d      = S_DONE;
                    done_d       = 1'b1;
`endif
                end else begin
                    shift_d      = shifted;
                    cnt_d        = cnt_q + CNT_W'(1);
                    sout_d       = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
                    sout_valid_d = 1'b1;
                end
            end

`ifdef DSWITCH_SER_PARITY_EN
            S_PAR: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`endif

            S_DONE: begin
                state_d      = S_IDLE;
                load_ready_d = 1'b1;
            end

            default: begin
                state_d      = S_IDLE;
                load_ready_d = 1'b1;
            end
        endcase
    end

    assign load_ready = load_ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule
